// File: rtl/config_byte_packer.sv
// ---------------------------------------------------------------------------
// config_byte_packer
//
// Front end of the eFPGA configuration port. Bytes from the host link are
// scanned for a 32-bit sync word. Once synced, bytes are packed MSB-first
// into 32-bit words: one frame-address word, then NUMBER_OF_ROWS data words,
// repeating. Each packed word is handed to the frame loader with a one-cycle
// strobe. A frame-address word with the desync bit set ends the session.
// A long idle gap while synced also ends the session.
//
// Ports
//   clk          in   fabric clock, every register updates on its rising edge
//   reset        in   synchronous, active-high
//   rx_data      in   [7:0] received byte
//   rx_valid     in   one-cycle pulse per received byte (no backpressure)
//   write_data   out  [31:0] assembled configuration word
//   write_strobe out  one-cycle pulse, write_data valid in that cycle
//   com_active   out  high while synced (ADDR or DATA)
//   receive_led  out  high while a byte arrived within LED_HOLD_CYCLES cycles
// ---------------------------------------------------------------------------
module config_byte_packer #(
    parameter logic [31:0] SYNC_WORD       = 32'hFAB0_FAB1,
    parameter int          NUMBER_OF_ROWS  = 4,
    parameter int          DESYNC_FLAG     = 20,
    parameter int          TIMEOUT_CYCLES  = 12_500_000,
    parameter int          LED_HOLD_CYCLES = 1_250_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] write_data,
    output logic        write_strobe,
    output logic        com_active,
    output logic        receive_led
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LED_W  = $clog2(LED_HOLD_CYCLES + 1);
    localparam int WORD_W = $clog2(NUMBER_OF_ROWS + 1);

    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [LED_W-1:0]  LED_LOAD   = LED_W'(LED_HOLD_CYCLES);
    localparam logic [WORD_W-1:0] ROWS_LAST  = WORD_W'(NUMBER_OF_ROWS - 1);

    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]        state_q,       state_d;
    logic [31:0]       hunt_q,        hunt_d;
    logic [31:0]       pack_q,        pack_d;
    logic [1:0]        byteCnt_q,     byteCnt_d;
    logic [WORD_W-1:0] wordCnt_q,     wordCnt_d;
    logic [IDLE_W-1:0] idleCnt_q,     idleCnt_d;
    logic [LED_W-1:0]  ledCnt_q,      ledCnt_d;
    logic [31:0]       writeData_q,   writeData_d;
    logic              writeStrobe_q, writeStrobe_d;
    logic              comActive_q,   comActive_d;
    logic              receiveLed_q,  receiveLed_d;

    logic [31:0]       huntShift;
    logic [31:0]       wordDone;
    logic [IDLE_W-1:0] idleNext;

    // Sliding window over the incoming stream and the word that the current
    // byte would complete (upper three lanes are already held in pack_q).
    assign huntShift = {hunt_q[23:0], rx_data};
    assign wordDone  = {pack_q[31:8], rx_data};

    // Idle count saturates at the limit instead of wrapping around.
    assign idleNext  = (idleCnt_q == IDLE_LIMIT) ? idleCnt_q : idleCnt_q + IDLE_W'(1);

    // Next-state logic for the sync hunt, the packer and the session timeout.
    always_comb begin
        state_d       = state_q;
        hunt_d        = hunt_q;
        pack_d        = pack_q;
        byteCnt_d     = byteCnt_q;
        wordCnt_d     = wordCnt_q;
        idleCnt_d     = idleCnt_q;
        writeData_d   = writeData_q;
        writeStrobe_d = 1'b0;

        case (state_q)
            ST_HUNT: begin
                idleCnt_d = '0;
                if (rx_valid) begin
                    hunt_d = huntShift;
                    if (huntShift == SYNC_WORD) begin
                        state_d   = ST_ADDR;
                        byteCnt_d = 2'd0;
                        wordCnt_d = '0;
                    end
                end
            end

            ST_ADDR, ST_DATA: begin
                if (rx_valid) begin
                    idleCnt_d = '0;
                    byteCnt_d = byteCnt_q + 2'd1;
                    case (byteCnt_q)
                        2'd0:    pack_d[31:24] = rx_data;
                        2'd1:    pack_d[23:16] = rx_data;
                        2'd2:    pack_d[15:8]  = rx_data;
                        default: pack_d[7:0]   = rx_data;
                    endcase
                    if (byteCnt_q == 2'd3) begin
                        if (state_q == ST_ADDR) begin
                            if (wordDone[DESYNC_FLAG]) begin
                                // End of session: the old window must not
                                // contribute to the next sync match.
                                state_d   = ST_HUNT;
                                hunt_d    = '0;
                                wordCnt_d = '0;
                            end else begin
                                writeStrobe_d = 1'b1;
                                writeData_d   = wordDone;
                                state_d       = ST_DATA;
                                wordCnt_d     = '0;
                            end
                        end else begin
                            writeStrobe_d = 1'b1;
                            writeData_d   = wordDone;
                            if (wordCnt_q == ROWS_LAST) begin
                                state_d   = ST_ADDR;
                                wordCnt_d = '0;
                            end else begin
                                wordCnt_d = wordCnt_q + WORD_W'(1);
                            end
                        end
                    end
                end else begin
                    idleCnt_d = idleNext;
                    if (idleNext == IDLE_LIMIT) begin
                        // Link went quiet mid-session: drop any partial word.
                        state_d   = ST_HUNT;
                        hunt_d    = '0;
                        pack_d    = '0;
                        byteCnt_d = 2'd0;
                        wordCnt_d = '0;
                        idleCnt_d = '0;
                    end
                end
            end

            default: begin
                state_d   = ST_HUNT;
                hunt_d    = '0;
                pack_d    = '0;
                byteCnt_d = 2'd0;
                wordCnt_d = '0;
                idleCnt_d = '0;
            end
        endcase
    end

    // Receive LED stretcher: any byte, in any state, reloads the hold time.
    always_comb begin
        ledCnt_d = ledCnt_q;
        if (rx_valid) begin
            ledCnt_d = LED_LOAD;
        end else if (ledCnt_q != '0) begin
            ledCnt_d = ledCnt_q - LED_W'(1);
        end
    end

    // Output flags are derived from next-state values so that the registered
    // outputs change in the cycle right after the triggering edge.
    always_comb begin
        comActive_d  = (state_d == ST_ADDR) || (state_d == ST_DATA);
        receiveLed_d = (ledCnt_d != '0);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_HUNT;
            hunt_q        <= '0;
            pack_q        <= '0;
            byteCnt_q     <= 2'd0;
            wordCnt_q     <= '0;
            idleCnt_q     <= '0;
            ledCnt_q      <= '0;
            writeData_q   <= '0;
            writeStrobe_q <= 1'b0;
            comActive_q   <= 1'b0;
            receiveLed_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            hunt_q        <= hunt_d;
            pack_q        <= pack_d;
            byteCnt_q     <= byteCnt_d;
            wordCnt_q     <= wordCnt_d;
            idleCnt_q     <= idleCnt_d;
            ledCnt_q      <= ledCnt_d;
            writeData_q   <= writeData_d;
            writeStrobe_q <= writeStrobe_d;
            comActive_q   <= comActive_d;
            receiveLed_q  <= receiveLed_d;
        end
    end

    assign write_data   = writeData_q;
    assign write_strobe = writeStrobe_q;
    assign com_active   = comActive_q;
    assign receive_led  = receiveLed_q;

endmodule

// File: tb/tb_config_byte_packer.sv
// ---------------------------------------------------------------------------
// tb_config_byte_packer
//
// Directed bench for config_byte_packer with a short timeout (16 cycles) and
// a short LED hold (8 cycles). Bytes are driven on the falling edge. Outputs
// are sampled on the falling edge. A monitor records every write strobe with
// its data and cycle number.
// ---------------------------------------------------------------------------
module tb_config_byte_packer;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] write_data;
    logic        write_strobe;
    logic        com_active;
    logic        receive_led;

    int          vecCount;
    int          errCount;
    int          cycleCount;

    logic [31:0] capData[$];
    int          capCycle[$];

    config_byte_packer #(
        .SYNC_WORD       (32'hFAB0_FAB1),
        .NUMBER_OF_ROWS  (4),
        .DESYNC_FLAG     (20),
        .TIMEOUT_CYCLES  (16),
        .LED_HOLD_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .write_data   (write_data),
        .write_strobe (write_strobe),
        .com_active   (com_active),
        .receive_led  (receive_led)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure strobe spacing.
    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
    end

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (write_strobe) begin
            capData.push_back(write_data);
            capCycle.push_back(cycleCount);
        end
    end

    // Compares one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drives one byte for exactly one cycle; returns on the next falling edge.
    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic applyWord(input logic [31:0] w);
        applyStimulus(w[31:24]);
        applyStimulus(w[23:16]);
        applyStimulus(w[15:8]);
        applyStimulus(w[7:0]);
    endtask

    task automatic idleCycles(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] capAt(input int i);
        if (i < capData.size()) return capData[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] gapAt(input int i);
        if (i + 1 < capCycle.size()) return 32'(capCycle[i+1] - capCycle[i]);
        return 32'hxxxx_xxxx;
    endfunction

    logic [31:0] frameWords[5];
    int          base;

    initial begin
        vecCount   = 0;
        errCount   = 0;
        cycleCount = 0;
        reset      = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;

        frameWords[0] = 32'h0000_0003;
        frameWords[1] = 32'h1122_3344;
        frameWords[2] = 32'h5566_7788;
        frameWords[3] = 32'h99AA_BBCC;
        frameWords[4] = 32'hDDEE_FF00;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_data",   write_data,   32'h0);
        checkOutput("reset_strobe", 32'(write_strobe), 32'h0);
        checkOutput("reset_com",    32'(com_active),   32'h0);
        checkOutput("reset_led",    32'(receive_led),  32'h0);

        // Bytes while hunting produce nothing; LED rises after first byte.
        applyStimulus(8'h01);
        checkOutput("led_rise", 32'(receive_led), 32'h1);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        applyStimulus(8'h04);
        idleCycles(1);
        checkOutput("hunt_nostrobe", 32'(capData.size()), 32'd0);
        checkOutput("hunt_com",      32'(com_active),     32'h0);

        // Junk byte, sync, address word and four data words.
        applyStimulus(8'h55);
        applyStimulus(8'hFA);
        applyStimulus(8'hB0);
        applyStimulus(8'hFA);
        checkOutput("presync_com", 32'(com_active), 32'h0);
        applyStimulus(8'hB1);
        checkOutput("sync_com", 32'(com_active), 32'h1);
        for (int i = 0; i < 5; i++) applyWord(frameWords[i]);
        idleCycles(2);
        checkOutput("frame_count", 32'(capData.size()), 32'd5);
        for (int i = 0; i < 5; i++) checkOutput($sformatf("frame_word%0d", i), capAt(i), frameWords[i]);
        checkOutput("frame_com", 32'(com_active), 32'h1);

        // Desync word (bit 20 set) is taken as an address: no strobe.
        applyWord(32'h0010_0000);
        checkOutput("desync_com", 32'(com_active), 32'h0);
        applyWord(32'h0000_0001);
        idleCycles(2);
        checkOutput("desync_nostrobe", 32'(capData.size()), 32'd5);
        checkOutput("desync_hold_data", write_data, 32'hDDEE_FF00);

        // Timeout after a partial word, exact at 16 idle cycles.
        applyWord(32'hFAB0_FAB1);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        idleCycles(15);
        checkOutput("timeout_15", 32'(com_active), 32'h1);
        idleCycles(1);
        checkOutput("timeout_16", 32'(com_active), 32'h0);
        applyWord(32'hFAB0_FAB1);
        applyWord(32'h0000_0007);
        idleCycles(1);
        checkOutput("resync_count", 32'(capData.size()), 32'd6);
        checkOutput("resync_addr",  capAt(5), 32'h0000_0007);

        // Byte on the 16th cycle beats the timeout.
        idleCycles(14);
        applyStimulus(8'h12);
        checkOutput("race_com", 32'(com_active), 32'h1);
        applyStimulus(8'h34);
        applyStimulus(8'h56);
        applyStimulus(8'h78);
        idleCycles(1);
        checkOutput("race_word", capAt(6), 32'h1234_5678);

        // Back-to-back stream: 3 data words, next address, 1 data word.
        base = capData.size();
        for (int i = 0; i < 20; i++) applyStimulus(8'(8'h20 + i));
        idleCycles(7);
        checkOutput("led_hold7", 32'(receive_led), 32'h1);
        idleCycles(1);
        checkOutput("led_fall8", 32'(receive_led), 32'h0);
        checkOutput("b2b_count", 32'(capData.size() - base), 32'd5);
        checkOutput("b2b_w0", capAt(base + 0), 32'h2021_2223);
        checkOutput("b2b_w1", capAt(base + 1), 32'h2425_2627);
        checkOutput("b2b_w2", capAt(base + 2), 32'h2829_2A2B);
        checkOutput("b2b_addr", capAt(base + 3), 32'h2C2D_2E2F);
        checkOutput("b2b_w4", capAt(base + 4), 32'h3031_3233);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("b2b_gap%0d", i), gapAt(base + i), 32'd4);
        checkOutput("b2b_com", 32'(com_active), 32'h1);

        // Reset mid-word: session ends, no strobe follows.
        applyStimulus(8'hAB);
        applyStimulus(8'hCD);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        base = capData.size();
        applyStimulus(8'hEF);
        applyStimulus(8'h01);
        idleCycles(2);
        checkOutput("midreset_nostrobe", 32'(capData.size() - base), 32'd0);
        checkOutput("midreset_com",      32'(com_active),            32'h0);
        checkOutput("midreset_data",     write_data,                 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/config_byte_packer.md
# config_byte_packer

Upstream stage of the eFPGA configuration port. It consumes the byte stream delivered by the host link (UART or USB-CDC receiver) and hunts for a sync word. It then packs bytes MSB-first into 32-bit configuration words and emits each word with a one-cycle strobe to the fabric's frame loader. It also drives the communication-active flag and a stretched receive-activity LED.

## Interface
Parameters:
- `SYNC_WORD`, 32'hFAB0_FAB1: stream sync pattern. Must be nonzero.
- `NUMBER_OF_ROWS`, 4: data words following each frame-address word.
- `DESYNC_FLAG`, 20: bit index in a frame-address word that ends the session.
- `TIMEOUT_CYCLES`, 12_500_000: idle cycles, while synced, before falling back to hunting. Must be ≥2.
- `LED_HOLD_CYCLES`, 1_250_000: receive LED stretch length. Must be ≥1.

Ports:
- `clk` in 1: fabric clock (12.5 MHz). One clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle pulse per byte. No backpressure; every pulse is consumed.
- `write_data` out 32: assembled configuration word.
- `write_strobe` out 1: one-cycle pulse; `write_data` is valid in that cycle.
- `com_active` out 1: high while synced (states ADDR and DATA).
- `receive_led` out 1: high while a byte was accepted within the last `LED_HOLD_CYCLES` cycles.

## Operation
- States: HUNT, ADDR, DATA.
- **HUNT**
  - Each valid byte shifts into a 32-bit hunt register: `hunt <= {hunt[23:0], rx_data}`.
  - If the shifted value equals `SYNC_WORD`: go to ADDR, clear the byte counter, clear the word counter.
  - No strobes are issued in HUNT.
- **ADDR / DATA packing**
  - A 2-bit byte counter selects the lane. The first byte lands in [31:24], the fourth in [7:0].
  - On the fourth byte, the word completes.
- **ADDR** (frame address):
  - If word bit `DESYNC_FLAG` = 1: no strobe; go to HUNT; clear the hunt register.
  - Otherwise: strobe the word; go to DATA with word counter = 0.
- **DATA**:
  - Every completed word is strobed and the word counter increments.
  - After `NUMBER_OF_ROWS` words: return to ADDR and clear the word counter.
- **Timeout**
  - In ADDR/DATA, an idle counter increments each cycle without `rx_valid` and clears on `rx_valid`.
  - Reaching `TIMEOUT_CYCLES`: go to HUNT; discard partial bytes; clear the byte counter, word counter and hunt register.
  - Width is `$clog2(TIMEOUT_CYCLES+1)`; the counter saturates rather than wrapping.
- **LED**
  - The LED counter loads `LED_HOLD_CYCLES` on any `rx_valid`, in any state, and decrements to 0.
  - `receive_led` = (counter ≠ 0).
- **Reset**
  - State HUNT; all counters 0, hunt register 0.
  - Outputs `write_data`=0, `write_strobe`=0, `com_active`=0, `receive_led`=0.
  - Reset mid-word discards partial data; no strobe follows reset.

## Timing
- All outputs are registered.
- Fourth byte of a word sampled at edge N:
  - `write_strobe`=1 and `write_data` valid in cycle N+1, for exactly one cycle.
  - `write_data` holds its value until the next strobe.
- Sync completion at edge N: `com_active`=1 from N+1.
- Desync word or timeout at edge N: `com_active`=0 from N+1.
- Throughput: back-to-back `rx_valid` every cycle is supported. Strobes are then spaced exactly 4 cycles apart.
- Timeout boundary: `rx_valid` in the same cycle the idle count would reach `TIMEOUT_CYCLES` wins. The byte is accepted, the idle count clears, and no fallback occurs.
- The sync pattern split across HUNT bytes is matched at any byte alignment (sliding window).
- After a desync, sync requires four fresh bytes; earlier bytes never combine with new ones.
- Sync bytes arriving while synced are packed as data, with no resync.
- `receive_led` rises the cycle after the first byte. It falls `LED_HOLD_CYCLES` cycles after the last byte.

## Test plan
1. **Reset state:** assert `reset` 3 cycles → all outputs 0. Send bytes 01 02 03 04 → no strobe, `com_active`=0.
2. **Sync and frame:** send junk byte 55, then sync FA B0 FA B1, then address 00 00 00 03, then 4 data words 11223344, 55667788, 99AABBCC, DDEEFF00. Expect:
   - `com_active`=1 after the B1 byte.
   - Exactly 5 strobes, carrying 00000003, 11223344, 55667788, 99AABBCC, DDEEFF00.
   - State back to ADDR.
3. **Desync:** after case 2, send 00 10 00 00 (bit 20 set) → no strobe; `com_active`=0 the next cycle. Then send 00 00 00 01 → no strobe.
4. **Timeout:** with `TIMEOUT_CYCLES`=16, sync, then send 2 bytes, then idle 16 cycles → `com_active` falls. Re-sync plus address 00 00 00 07 → strobe carries 00000007, with no stale bytes.
5. **Timeout race:** idle 15 cycles, then `rx_valid` on the 16th → `com_active` stays 1.
6. **Back-to-back and LED:** stream 20 bytes every cycle after sync → strobes every 4 cycles. With `LED_HOLD_CYCLES`=8, `receive_led` falls exactly 8 cycles after the last byte.
